iiitb_icg_ctrl: RTL and testbench

IIITB_ICG_CTRL -- requirements
Module: iiitb_icg_ctrl

---
 rtl/iiitb_icg.sv | 149 ++++++++++++++
 tb/tb_iiitb_icg_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/iiitb_icg.sv
// rtl/iiitb_icg.sv - clock-gate controller: wake/idle sequencing and round-robin grant of the gated domain
module iiitb_icg_ctrl #(
    parameter int unsigned IDLE_CYCLES = 8,
    parameter int unsigned WAKE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic       done,
    input  logic       force_on,
    output logic       gate_en,
    output logic       gnt0,
    output logic       gnt1,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_OFF    = 2'b00,
        ST_WAKE   = 2'b01,
        ST_ACTIVE = 2'b10,
        ST_IDLE   = 2'b11
    } state_t;

    localparam logic [3:0] WAKE_LOAD = 4'(WAKE_CYCLES - 1);
    localparam logic [7:0] IDLE_LAST = 8'(IDLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] wake_cnt_q, wake_cnt_d;
    logic [7:0] idle_cnt_q, idle_cnt_d;
    logic       ptr_q, ptr_d;
    logic       gnt0_q, gnt0_d;
    logic       gnt1_q, gnt1_d;
    logic       gate_en_q, gate_en_d;
    logic       arm_q, arm_d;

    logic any_req;
    logic pick1;

    // Round-robin choice: on a tie the requester not granted last wins;
    // ptr_q holds the last-granted index, so on done this also prefers the other side.
    always_comb begin
        any_req = req0 | req1;
        pick1   = (req0 & req1) ? ~ptr_q : req1;
    end

    // Next-state, counters, grants; the FSM stays frozen for one edge after reset release.
    always_comb begin
        state_d    = state_q;
        wake_cnt_d = wake_cnt_q;
        idle_cnt_d = idle_cnt_q;
        ptr_d      = ptr_q;
        gnt0_d     = gnt0_q;
        gnt1_d     = gnt1_q;
        arm_d      = 1'b1;

        if (arm_q) begin
            case (state_q)
                ST_OFF: begin
                    if (any_req | force_on) begin
                        state_d    = ST_WAKE;
                        wake_cnt_d = WAKE_LOAD;
                    end
                end
                ST_WAKE: begin
                    if (wake_cnt_q == 4'd0) begin
                        if (any_req) begin
                            state_d = ST_ACTIVE;
                            gnt0_d  = ~pick1;
                            gnt1_d  = pick1;
                            ptr_d   = pick1;
                        end else begin
                            state_d    = ST_IDLE;
                            idle_cnt_d = 8'd0;
                        end
                    end else begin
                        wake_cnt_d = wake_cnt_q - 4'd1;
                    end
                end
                ST_ACTIVE: begin
                    if (done && (gnt0_q || gnt1_q)) begin
                        if (any_req) begin
                            gnt0_d = ~pick1;
                            gnt1_d = pick1;
                            ptr_d  = pick1;
                        end else begin
                            state_d    = ST_IDLE;
                            gnt0_d     = 1'b0;
                            gnt1_d     = 1'b0;
                            idle_cnt_d = 8'd0;
                        end
                    end
                end
                ST_IDLE: begin
                    if (any_req) begin
                        state_d    = ST_ACTIVE;
                        gnt0_d     = ~pick1;
                        gnt1_d     = pick1;
                        ptr_d      = pick1;
                        idle_cnt_d = 8'd0;
                    end else if (force_on) begin
                        idle_cnt_d = 8'd0;
                    end else if (idle_cnt_q == IDLE_LAST) begin
                        state_d    = ST_OFF;
                        idle_cnt_d = 8'd0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    gnt0_d  = 1'b0;
                    gnt1_d  = 1'b0;
                end
            endcase
        end

        gate_en_d = (state_d != ST_OFF);
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_OFF;
            wake_cnt_q <= 4'd0;
            idle_cnt_q <= 8'd0;
            ptr_q      <= 1'b1;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            gate_en_q  <= 1'b0;
            arm_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wake_cnt_q <= wake_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            ptr_q      <= ptr_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            gate_en_q  <= gate_en_d;
            arm_q      <= arm_d;
        end
    end

    assign gate_en = gate_en_q;
    assign gnt0    = gnt0_q;
    assign gnt1    = gnt1_q;
    assign state   = state_q;

endmodule

// File: tb/tb_iiitb_icg_ctrl.sv
// tb/tb_iiitb_icg_ctrl.sv - directed and randomized check of iiitb_icg_ctrl against a behavioural model
module tb_iiitb_icg_ctrl;

    localparam int WAKE_CYCLES = 2;
    localparam int IDLE_CYCLES = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req0 = 1'b0;
    logic       req1 = 1'b0;
    logic       done = 1'b0;
    logic       force_on = 1'b0;
    logic       gate_en;
    logic       gnt0;
    logic       gnt1;
    logic [1:0] state;

    int n_checks = 0;
    int n_errors = 0;

    // model: mode 0=OFF 1=WAKE 2=ACTIVE 3=IDLE; holder -1 = nobody
    int m_state;
    int m_holder;
    int m_last;
    int m_wait;
    int m_idle;
    bit m_arm;

    iiitb_icg_ctrl #(.IDLE_CYCLES(IDLE_CYCLES), .WAKE_CYCLES(WAKE_CYCLES)) dut (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1), .done(done),
        .force_on(force_on), .gate_en(gate_en), .gnt0(gnt0), .gnt1(gnt1), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state  = 0;
        m_holder = -1;
        m_last   = 1;
        m_wait   = 0;
        m_idle   = 0;
        m_arm    = 1'b0;
    endtask

    task automatic grant_fresh(input bit r0, input bit r1);
        if (r0 && r1) m_holder = (m_last == 1) ? 0 : 1;
        else          m_holder = r1 ? 1 : 0;
        m_last  = m_holder;
        m_state = 2;
    endtask

    task automatic model_edge(input bit r0, input bit r1, input bit d, input bit f);
        bit req_of[2];
        int other;
        req_of[0] = r0;
        req_of[1] = r1;
        if (!m_arm) begin
            m_arm = 1'b1;
            return;
        end
        case (m_state)
            0: if (r0 || r1 || f) begin
                m_state = 1;
                m_wait  = WAKE_CYCLES;
            end
            1: begin
                m_wait--;
                if (m_wait == 0) begin
                    if (r0 || r1) grant_fresh(r0, r1);
                    else begin m_state = 3; m_idle = 0; end
                end
            end
            2: if (d) begin
                other = 1 - m_holder;
                if (req_of[other]) begin
                    m_holder = other;
                    m_last   = other;
                end else if (!req_of[m_holder]) begin
                    m_holder = -1;
                    m_state  = 3;
                    m_idle   = 0;
                end
            end
            default: begin
                if (r0 || r1) grant_fresh(r0, r1);
                else if (f) m_idle = 0;
                else begin
                    m_idle++;
                    if (m_idle >= IDLE_CYCLES) begin
                        m_state = 0;
                        m_idle  = 0;
                    end
                end
            end
        endcase
    endtask

    task automatic cyc();
        @(posedge clk);
        if (!reset) model_reset();
        else model_edge(req0, req1, done, force_on);
        #1;
        check("state", int'(state), m_state);
        check("gate_en", int'(gate_en), (m_state != 0) ? 1 : 0);
        check("gnt0", int'(gnt0), (m_holder == 0) ? 1 : 0);
        check("gnt1", int'(gnt1), (m_holder == 1) ? 1 : 0);
        check("gnt_excl", int'(gnt0 & gnt1), 0);
    endtask

    initial begin
        int cnt;
        bit found;
        model_reset();

        // held in reset
        #1;
        check("rst_state", int'(state), 0);
        check("rst_gate_en", int'(gate_en), 0);
        repeat (3) cyc();

        // release, req0 waiting: arm edge, then WAKE for two edges, then grant
        reset = 1'b1;
        req0  = 1'b1;
        cyc();
        check("arm_edge_state", int'(state), 0);
        cyc();
        check("wake_state", int'(state), 1);
        check("wake_gate_en", int'(gate_en), 1);
        cyc();
        check("wake_gnt0_low", int'(gnt0), 0);
        cyc();
        check("first_gnt0", int'(gnt0), 1);
        check("active_state", int'(state), 2);
        req0 = 1'b0;

        // handover to requester 1 on done
        req1 = 1'b1;
        cyc();
        done = 1'b1;
        cyc();
        done = 1'b0;
        check("handover_gnt0", int'(gnt0), 0);
        check("handover_gnt1", int'(gnt1), 1);
        check("handover_state", int'(state), 2);
        req1 = 1'b0;

        // release with no requests -> IDLE, then timeout to OFF
        done = 1'b1;
        cyc();
        done = 1'b0;
        check("idle_entry", int'(state), 3);
        cnt = 0;
        for (int i = 0; i < 20 && gate_en; i++) begin
            cyc();
            cnt++;
        end
        check("idle_timeout_cycles", cnt, IDLE_CYCLES);

        // force_on wakes and keeps the clock running
        force_on = 1'b1;
        repeat (3) cyc();
        check("force_idle_state", int'(state), 3);
        repeat (20) cyc();
        check("force_hold_gate_en", int'(gate_en), 1);
        force_on = 1'b0;

        // request arriving in the last idle cycle wins over the timeout
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cyc();
            if (m_idle == IDLE_CYCLES - 1) found = 1'b1;
        end
        check("reach_last_idle", int'(found), 1);
        req1 = 1'b1;
        cyc();
        check("late_req_gnt1", int'(gnt1), 1);
        check("late_req_gate_en", int'(gate_en), 1);

        // asynchronous reset while gnt1 is high
        #3;
        reset = 1'b0;
        #1;
        check("async_gnt1", int'(gnt1), 0);
        check("async_gate_en", int'(gate_en), 0);
        check("async_state", int'(state), 0);
        req1 = 1'b0;
        repeat (2) cyc();

        // simultaneous requests after reset: req0 wins the first tie
        reset = 1'b1;
        req0  = 1'b1;
        req1  = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10 && !(gnt0 || gnt1); i++) begin
            cyc();
            cnt++;
        end
        check("tie_gnt0", int'(gnt0), 1);
        check("tie_latency", cnt, WAKE_CYCLES + 2);
        req0 = 1'b0;
        done = 1'b1;
        cyc();
        done = 1'b0;
        check("tie_second_gnt1", int'(gnt1), 1);
        req1 = 1'b0;
        done = 1'b1;
        cyc();
        done = 1'b0;
        check("tie_to_idle", int'(state), 3);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if (!reset) reset = 1'b1;
            else if ($urandom_range(0, 399) == 0) reset = 1'b0;
            req0 = (req0 && m_holder != 0) ? 1'b1 :
                   (m_holder == 0) ? 1'($urandom_range(0, 1)) : 1'($urandom_range(0, 5) == 0);
            req1 = (req1 && m_holder != 1) ? 1'b1 :
                   (m_holder == 1) ? 1'($urandom_range(0, 1)) : 1'($urandom_range(0, 5) == 0);
            done = (m_holder >= 0) ? 1'($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 39) == 0) force_on = ~force_on;
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
